// File: rtl/riscv_mem_pkg.sv
// Shared memory-access definitions for the decoder and the load/store unit:
// MemOp encodings, LSU completion error codes and the LSU state encoding.
package riscv_mem_pkg;

    // MemOp field as produced by the decoder (funct3-style load/store width)
    localparam logic [2:0] MEMOP_B  = 3'b000;  // byte, sign-extended on load
    localparam logic [2:0] MEMOP_BU = 3'b001;  // byte, zero-extended on load
    localparam logic [2:0] MEMOP_H  = 3'b010;  // halfword, sign-extended on load
    localparam logic [2:0] MEMOP_HU = 3'b011;  // halfword, zero-extended on load
    localparam logic [2:0] MEMOP_W  = 3'b100;  // word

    // Completion status reported alongside done
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // LSU control FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: turns a MemOp code and the low address bits
// into bus byte enables, lane-replicated store data and the sign/zero-extended
// load result, and classifies the request as illegal or misaligned.
// Purely combinational; the caller decides which memop/address to present.
module lsu_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_memop,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata_ext,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the raw bus word
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Byte enables, replicated store data and extended load data per access width
    always_comb begin
        o_be        = 4'b0000;
        o_wdata     = 32'h0;
        o_rdata_ext = 32'h0;
        case (i_memop)
            MEMOP_B, MEMOP_BU: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_wdata[7:0]}};
                o_rdata_ext = (i_memop == MEMOP_B) ? {{24{w_byte[7]}}, w_byte}
                                                   : {24'h0, w_byte};
            end
            MEMOP_H, MEMOP_HU: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata     = {2{i_wdata[15:0]}};
                o_rdata_ext = (i_memop == MEMOP_H) ? {{16{w_half[15]}}, w_half}
                                                   : {16'h0, w_half};
            end
            MEMOP_W: begin
                o_be        = 4'b1111;
                o_wdata     = i_wdata;
                o_rdata_ext = i_rdata;
            end
            default: begin
                o_be        = 4'b0000;
                o_wdata     = 32'h0;
                o_rdata_ext = 32'h0;
            end
        endcase
    end

    // Request classification; the FSM gives illegal priority over misaligned
    always_comb begin
        o_illegal  = (i_memop > MEMOP_W);
        o_misalign = 1'b0;
        if (i_memop == MEMOP_H || i_memop == MEMOP_HU) begin
            o_misalign = i_addr_lo[0];
        end else if (i_memop == MEMOP_W) begin
            o_misalign = (i_addr_lo != 2'b00);
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one memory request at a time from the execute
// stage, runs a single req/ack transaction on the word-addressed data bus and
// returns formatted load data or an error code with a one-cycle done pulse.
// Requests that fail the alignment/legality checks never reach the bus.
module lsu_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_valid,
    input  logic        core_we,
    input  logic [2:0]  core_memop,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter value on the last ACCESS cycle that may still see an ack
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_memop;
    logic [1:0]  r_addr_lo;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_err;

    logic        w_idle;
    logic [2:0]  w_memop;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata_ext;
    logic        w_misalign;
    logic        w_illegal;

    // In IDLE the aligner looks at the incoming request (checks, be, wdata);
    // afterwards it looks at the latched request so the load lane comes from
    // the address that was actually sent to the bus.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_memop   = w_idle ? core_memop     : r_memop;
    assign w_addr_lo = w_idle ? core_addr[1:0] : r_addr_lo;

    lsu_lane_align u_align (
        .i_memop     (w_memop),
        .i_addr_lo   (w_addr_lo),
        .i_wdata     (core_wdata),
        .i_rdata     (bus_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_rdata_ext (w_rdata_ext),
        .o_misalign  (w_misalign),
        .o_illegal   (w_illegal)
    );

    // Control FSM, timeout counter and all registered bus/response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_memop     <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_err       <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 8'd0;
                    if (core_valid) begin
                        if (w_illegal) begin
                            r_err   <= ERR_ILLEGAL;
                            r_rdata <= 32'h0;
                            r_state <= ST_RESP;
                        end else if (w_misalign) begin
                            r_err   <= ERR_MISALIGN;
                            r_rdata <= 32'h0;
                            r_state <= ST_RESP;
                        end else begin
                            r_memop     <= core_memop;
                            r_addr_lo   <= core_addr[1:0];
                            r_bus_we    <= core_we;
                            r_bus_addr  <= {core_addr[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= core_we ? w_wdata : 32'h0;
                            r_err       <= ERR_OK;
                            r_state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (bus_ack) begin
                        // Stores complete with zero read data
                        r_rdata  <= r_bus_we ? 32'h0 : w_rdata_ext;
                        r_err    <= ERR_OK;
                        r_bus_we <= 1'b0;
                        r_state  <= ST_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_rdata  <= 32'h0;
                        r_err    <= ERR_TIMEOUT;
                        r_bus_we <= 1'b0;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_cnt   <= 8'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt   <= 8'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and bus strobes follow directly from the registered state
    assign busy      = !w_idle;
    assign done      = (r_state == ST_RESP);
    assign bus_req   = (r_state == ST_ACCESS);
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl: loads with sign/zero extension,
// delayed ack, byte store replication, alignment/legality errors, bus
// timeout, reset during an access and ignored back-to-back requests.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        core_valid;
    logic        core_we;
    logic [2:0]  core_memop;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_valid (core_valid),
        .core_we    (core_we),
        .core_memop (core_memop),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [2:0] memop,
                       input logic [31:0] addr, input logic [31:0] wdata);
        core_valid = 1'b1;
        core_we    = we;
        core_memop = memop;
        core_addr  = addr;
        core_wdata = wdata;
    endtask

    initial begin
        int busy_n;
        int req_n;
        int done_n;
        logic done_seen;
        logic [1:0] err_seen;

        rst = 1'b1; core_valid = 1'b0; core_we = 1'b0; core_memop = 3'd0;
        core_addr = 32'h0; core_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        tick(); tick();

        // Reset state
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_req", {31'h0, bus_req}, 32'd0);
        chk("rst_we", {31'h0, bus_we}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {30'h0, err}, 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_be", {28'h0, bus_be}, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        rst = 1'b0;
        tick();

        // 1: lb 0x1003, ack on first request cycle
        req(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        tick();
        core_valid = 1'b0;
        chk("t1_req", {31'h0, bus_req}, 32'd1);
        chk("t1_busy", {31'h0, busy}, 32'd1);
        chk("t1_addr", bus_addr, 32'h0000_1000);
        chk("t1_be", {28'h0, bus_be}, 32'h8);
        chk("t1_we", {31'h0, bus_we}, 32'd0);
        chk("t1_wdata", bus_wdata, 32'h0);
        chk("t1_done_c1", {31'h0, done}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h8000_0000;
        tick();
        bus_ack = 1'b0;
        chk("t1_done", {31'h0, done}, 32'd1);
        chk("t1_rdata", rdata, 32'hFFFF_FF80);
        chk("t1_err", {30'h0, err}, 32'd0);
        chk("t1_req_off", {31'h0, bus_req}, 32'd0);
        tick();
        chk("t1_done_off", {31'h0, done}, 32'd0);
        chk("t1_idle", {31'h0, busy}, 32'd0);

        // 2: lhu 0x2002, ack three cycles late
        req(1'b0, 3'b011, 32'h0000_2002, 32'h0);
        bus_rdata = 32'hBEEF_1234;
        busy_n = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            core_valid = 1'b0;
            busy_n += int'(busy);
            if (i <= 4) begin
                chk($sformatf("t2_req_c%0d", i), {31'h0, bus_req}, 32'd1);
                chk($sformatf("t2_addr_c%0d", i), bus_addr, 32'h0000_2000);
                chk($sformatf("t2_be_c%0d", i), {28'h0, bus_be}, 32'hC);
                chk($sformatf("t2_done_c%0d", i), {31'h0, done}, 32'd0);
            end
            if (i == 5) begin
                chk("t2_done", {31'h0, done}, 32'd1);
                chk("t2_rdata", rdata, 32'h0000_BEEF);
                chk("t2_err", {30'h0, err}, 32'd0);
            end
            bus_ack = (i == 4);
        end
        chk("t2_busy_cycles", busy_n, 32'd5);

        // 3: sb 0x11, data 0xA5
        req(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5);
        tick();
        core_valid = 1'b0;
        chk("t3_we", {31'h0, bus_we}, 32'd1);
        chk("t3_addr", bus_addr, 32'h0000_0010);
        chk("t3_be", {28'h0, bus_be}, 32'h2);
        chk("t3_wdata", bus_wdata, 32'hA5A5_A5A5);
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_ack = 1'b0;
        chk("t3_done", {31'h0, done}, 32'd1);
        chk("t3_rdata", rdata, 32'h0);
        chk("t3_err", {30'h0, err}, 32'd0);
        tick();

        // 3b: lh 0x2 sign-extends the upper halfword
        req(1'b0, 3'b010, 32'h0000_0002, 32'h0);
        tick();
        core_valid = 1'b0;
        chk("t3b_be", {28'h0, bus_be}, 32'hC);
        bus_ack = 1'b1; bus_rdata = 32'h8001_0000;
        tick();
        bus_ack = 1'b0;
        chk("t3b_rdata", rdata, 32'hFFFF_8001);
        tick();

        // 4: misaligned lw, then illegal memop at the same address
        req(1'b0, 3'b100, 32'h0000_0006, 32'h0);
        tick();
        core_valid = 1'b0;
        chk("t4_done", {31'h0, done}, 32'd1);
        chk("t4_err", {30'h0, err}, 32'd1);
        chk("t4_noreq", {31'h0, bus_req}, 32'd0);
        chk("t4_rdata", rdata, 32'h0);
        tick();
        chk("t4_done_off", {31'h0, done}, 32'd0);
        req(1'b0, 3'b110, 32'h0000_0006, 32'h0);
        tick();
        core_valid = 1'b0;
        chk("t4_ill_done", {31'h0, done}, 32'd1);
        chk("t4_ill_err", {30'h0, err}, 32'd2);
        chk("t4_ill_noreq", {31'h0, bus_req}, 32'd0);
        tick();

        // 5: sw with no ack times out after 16 request cycles
        req(1'b1, 3'b100, 32'h0000_0040, 32'h1234_5678);
        tick();
        core_valid = 1'b0;
        chk("t5_be", {28'h0, bus_be}, 32'hF);
        chk("t5_wdata", bus_wdata, 32'h1234_5678);
        req_n = 0; done_seen = 1'b0; err_seen = 2'b00;
        for (int i = 0; i < 40; i++) begin
            req_n += int'(bus_req);
            if (done) begin
                done_seen = 1'b1;
                err_seen  = err;
                break;
            end
            tick();
        end
        chk("t5_done_seen", {31'h0, done_seen}, 32'd1);
        chk("t5_req_cycles", req_n, 32'd16);
        chk("t5_err", {30'h0, err_seen}, 32'd3);
        tick();
        chk("t5_idle", {31'h0, busy}, 32'd0);

        // 6a: reset during ACCESS aborts the access silently
        req(1'b0, 3'b000, 32'h0000_0000, 32'h0);
        tick();
        chk("t6_req_on", {31'h0, bus_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; core_valid = 1'b0;
        chk("t6_req_off", {31'h0, bus_req}, 32'd0);
        chk("t6_busy_off", {31'h0, busy}, 32'd0);
        done_n = int'(done);
        for (int i = 0; i < 3; i++) begin
            tick();
            done_n += int'(done);
        end
        chk("t6_no_done", done_n, 32'd0);

        // 6b: valid held during the access is ignored, one done only
        req(1'b0, 3'b001, 32'h0000_0001, 32'h0);
        bus_rdata = 32'h0000_F100;
        done_n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            core_valid = (i < 3);
            bus_ack    = (i == 2);
            done_n += int'(done);
            if (i == 3) chk("t6_rdata", rdata, 32'h0000_00F1);
        end
        chk("t6_one_done", done_n, 32'd1);
        chk("t6_end_idle", {31'h0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store execution unit: the consumer side of the decoder's MemWr/MemOp/MemtoReg control bundle.
- Takes one memory request per transaction from the datapath (ALU address, rs2 store data, MemOp code).
- Drives a word-addressed req/ack data bus with byte enables.
- Returns sign/zero-extended load data, or flags misaligned, illegal and timed-out accesses.
- Sits between the execute stage and data memory; the core stalls while busy=1.

Parameters:
TIMEOUT_CYCLES, 16, number of ACCESS-state cycles without bus_ack before the access is aborted with a timeout error (legal range 2..255).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
core_valid  input  1  request strobe, sampled only in IDLE
core_we  input  1  1=store (MemWr), 0=load
core_memop  input  3  000 byte signed, 001 byte unsigned, 010 half signed, 011 half unsigned, 100 word; 101-111 illegal
core_addr  input  32  byte address (rs1+imm)
core_wdata  input  32  store data (rs2)
busy  output  1  high from the cycle after an accepted request through the RESP cycle
done  output  1  one-cycle completion pulse
rdata  output  32  formatted load data, valid while done=1, 0 for stores and errors
err  output  2  00 ok, 01 misaligned, 10 illegal memop, 11 timeout; valid while done=1
bus_req  output  1  bus request
bus_we  output  1  bus write enable
bus_addr  output  32  word address, {core_addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  bus completion, may be asserted in the first bus_req cycle
bus_rdata  input  32  raw read word, valid with bus_ack

Behaviour:
- Reset: state=IDLE; busy, done, bus_req, bus_we=0; rdata, err, bus_addr, bus_be, bus_wdata=0; timeout counter=0.
- Reset mid-access: bus_req drops at the reset edge and no done is produced.

States and transitions:
- IDLE, core_valid=1, request illegal or misaligned: go to RESP. No bus access; err set as below.
- IDLE, core_valid=1, request legal: latch we/memop/addr/wdata, precompute bus_be/bus_wdata, go to ACCESS.
- ACCESS: bus_req=1. bus_we, bus_addr, bus_be and bus_wdata are held stable until the ack cycle.
  - On bus_ack: capture and format bus_rdata, go to RESP.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 with no ack: go to RESP with err=11; bus_req deasserts at that edge.
- RESP: done=1 for exactly one cycle, then IDLE; counter clears.
- core_valid while not IDLE is ignored; no queuing.
- Latency: valid at cycle 0, bus_req at cycle 1, ack at cycle 1, done at cycle 2. An error detected in IDLE gives done at cycle 1.

Error checks (illegal has priority over misaligned):
- Illegal: core_memop in 101-111.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.

Stores:
- Byte: be=0001<<addr[1:0]; wdata = core_wdata[7:0] replicated to all 4 lanes.
- Half: be=0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = core_wdata[15:0] replicated to both halves.
- Word: be=1111.
- For stores, rdata=0 at done.

Loads:
- be is computed as for stores; bus_wdata=0.
- The lane is selected by the latched addr[1:0].
- Sign-extend for codes 000/010; zero-extend for 001/011; pass through for 100.

Decomposition:
- Shared package riscv_mem_pkg:
  - MemOp code localparams (MEMOP_B, MEMOP_BU, MEMOP_H, MEMOP_HU, MEMOP_W), shared with the decoder.
  - Error-code constants (ERR_OK, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT).
  - State encoding (ST_IDLE, ST_ACCESS, ST_RESP).
- One combinational sub-module, lsu_lane_align: memop + addr[1:0] + wdata + raw rdata -> be, replicated wdata, extended rdata, misalign/illegal flags. The FSM and timeout counter stay in lsu_mem_ctrl.

Test Plan:
1. lb at addr 0x1003 (memop 000), bus_rdata=0x80_00_00_00, ack on first req cycle -> bus_addr=0x1000, be=1000, done at cycle 2, rdata=0xFFFFFF80, err=00.
2. lhu at addr 0x2002 (memop 011), bus_rdata=0xBEEF1234, ack delayed 3 cycles -> be=1100, bus outputs stable until ack, rdata=0x0000BEEF, busy held 5 cycles.
3. sb at addr 0x11 with wdata 0x000000A5 -> bus_we=1, bus_addr=0x10, be=0010, bus_wdata=0xA5A5A5A5; rdata=0 at done.
4. lw at addr 0x6 -> no bus_req, done at cycle 1, err=01. Memop 110 at addr 0x6 -> err=10, illegal wins over misaligned.
5. Legal sw with bus_ack held 0 and TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, then done with err=11, then IDLE.
6. Assert rst while in ACCESS -> bus_req=0 and busy=0 after that edge, no done pulse. core_valid pulsed during busy is ignored: exactly one done per accepted request.
